// File: rtl/hier_icache_ctrl_seq.sv
// hier_icache_ctrl_seq
// Sequences enable / disable / flush / selective-flush commands to a set of
// cache banks. A command fans out as per-channel level requests that drop as
// each targeted channel acknowledges. The command finishes when every target
// has acked or when the WAIT cycle budget runs out. On timeout, the channels
// that never answered are reported in fail_mask_o.
module hier_icache_ctrl_seq #(
    parameter int NB_CHANNELS    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_op_i,
    input  logic [NB_CHANNELS-1:0] cmd_mask_i,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr_i,

    output logic [NB_CHANNELS-1:0] enable_req_o,
    output logic [NB_CHANNELS-1:0] disable_req_o,
    output logic [NB_CHANNELS-1:0] flush_req_o,
    output logic [NB_CHANNELS-1:0] sel_flush_req_o,
    output logic [ADDR_WIDTH-1:0]  sel_flush_addr_o,
    input  logic [NB_CHANNELS-1:0] ack_i,

    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [NB_CHANNELS-1:0] fail_mask_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_ENABLE    = 2'd0,
        OP_DISABLE   = 2'd1,
        OP_FLUSH     = 2'd2,
        OP_SEL_FLUSH = 2'd3
    } op_e;

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [NB_CHANNELS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [NB_CHANNELS-1:0] fail_mask_q, fail_mask_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

    logic [NB_CHANNELS-1:0] enable_req_q, enable_req_d;
    logic [NB_CHANNELS-1:0] disable_req_q, disable_req_d;
    logic [NB_CHANNELS-1:0] flush_req_q, flush_req_d;
    logic [NB_CHANNELS-1:0] sel_flush_req_q, sel_flush_req_d;

    // Pending set once this cycle's acks are consumed; acks on channels that
    // are not pending fall out of the AND and are ignored.
    logic [NB_CHANNELS-1:0] pending_after_ack;
    assign pending_after_ack = pending_q & ~ack_i;

    // Next-state and datapath update: accept, ack consumption, completion
    // and timeout.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        op_d        = op_q;
        pending_d   = pending_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        fail_mask_d = fail_mask_q;
        addr_d      = addr_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d        = op_e'(cmd_op_i);
                    pending_d   = cmd_mask_i;
                    addr_d      = cmd_addr_i;
                    err_d       = 1'b0;
                    fail_mask_d = '0;
                    cnt_d       = '0;
                    state_d     = (|cmd_mask_i) ? S_WAIT : S_DONE;
                end
            end

            S_WAIT: begin
                pending_d = pending_after_ack;
                cnt_d     = cnt_q + CNT_ONE;
                // Completion is tested first so a last ack landing in the
                // final budget cycle still counts as success.
                if (pending_after_ack == '0) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    err_d       = 1'b1;
                    fail_mask_d = pending_after_ack;
                    pending_d   = '0;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                pending_d = '0;
            end
        endcase
    end

    // Request vectors for the next cycle: only the vector chosen by the
    // latched op mirrors the pending set, and only while waiting.
    always_comb begin
        enable_req_d    = '0;
        disable_req_d   = '0;
        flush_req_d     = '0;
        sel_flush_req_d = '0;
        if (state_d == S_WAIT) begin
            case (op_d)
                OP_ENABLE:    enable_req_d    = pending_d;
                OP_DISABLE:   disable_req_d   = pending_d;
                OP_FLUSH:     flush_req_d     = pending_d;
                OP_SEL_FLUSH: sel_flush_req_d = pending_d;
                default:      enable_req_d    = '0;
            endcase
        end
    end

    // State, bookkeeping and registered request outputs, cleared
    // asynchronously so requests drop the moment reset is raised.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: sequential state is updated with non-blocking assignments
            // only, so every flop samples the pre-edge values of the others.
            state_q         <= S_IDLE;
            op_q            <= OP_ENABLE;
            pending_q       <= '0;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            fail_mask_q     <= '0;
            addr_q          <= '0;
            enable_req_q    <= '0;
            disable_req_q   <= '0;
            flush_req_q     <= '0;
            sel_flush_req_q <= '0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            pending_q       <= pending_d;
            cnt_q           <= cnt_d;
            err_q           <= err_d;
            fail_mask_q     <= fail_mask_d;
            addr_q          <= addr_d;
            enable_req_q    <= enable_req_d;
            disable_req_q   <= disable_req_d;
            flush_req_q     <= flush_req_d;
            sel_flush_req_q <= sel_flush_req_d;
        end
    end

    // Outputs are flops or decodes of the state flop only, so nothing on the
    // command or ack inputs reaches an output in the same cycle.
    assign cmd_ready_o      = (state_q == S_IDLE);
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = (state_q == S_DONE);
    assign err_o            = err_q;
    assign fail_mask_o      = fail_mask_q;
    assign sel_flush_addr_o = addr_q;
    assign enable_req_o     = enable_req_q;
    assign disable_req_o    = disable_req_q;
    assign flush_req_o      = flush_req_q;
    assign sel_flush_req_o  = sel_flush_req_q;

endmodule
